key_debounce_pulse: RTL and testbench

- Conditions one raw mechanical push-button into a clean debounced level plus single-cycle press and release pulses.
- Its press pulse is the producer side of the start/stop toggle interface: it drives the start_stop_pulse input of the 0–30 counter and similar toggle-controlled blocks.
- Each press must produce exactly one pulse, regardless of contact bounce or hold duration.
- Sits between the board pin and the control logic, in the 100 MHz clk domain.

---
 rtl/key_pkg.sv | 17 +
 rtl/sync_2ff.sv | 22 ++
 rtl/key_debounce_pulse.sv | 92 +++++++++
 tb/tb_key_debounce_pulse.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared encodings and defaults for the push-button
// debounce/pulse conditioner.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } key_state_t;

  localparam int unsigned DEF_WIDTH = 24;

  localparam logic [DEF_WIDTH-1:0] DEF_DEBOUNCE_TICKS =
    24'd1_000_000;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser, synchronous
// active-high reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic ff1;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff1 <= 1'b0;
      q   <= 1'b0;
    end else begin
      ff1 <= d;
      q   <= ff1;
    end
  end

endmodule

// File: rtl/key_debounce_pulse.sv
// Debounces one raw button into a clean level
// plus single-cycle press/release strobes.
module key_debounce_pulse
  import key_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] DEBOUNCE_TICKS =
    DEF_DEBOUNCE_TICKS,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam logic [WIDTH-1:0] LAST =
    DEBOUNCE_TICKS - 1'b1;

  logic             p;
  logic             sync;
  key_state_t       state;
  logic [WIDTH-1:0] cnt;
  logic             cnt_done;

  assign p        = btn_in ^ ACTIVE_LOW;
  assign cnt_done = (cnt == LAST);

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (p),
    .q   (sync)
  );

  // Pulses default low every cycle, so they
  // can never stretch beyond one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (sync) begin
            state <= PRESS_CHK;
            cnt   <= '0;
          end
        end
        PRESS_CHK: begin
          if (!sync) begin
            state <= IDLE;
          end else if (cnt_done) begin
            state       <= HELD;
            btn_level   <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!sync) begin
            state <= RELEASE_CHK;
            cnt   <= '0;
          end
        end
        RELEASE_CHK: begin
          if (sync) begin
            state <= HELD;
          end else if (cnt_done) begin
            state         <= IDLE;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Randomised and directed checks of the button
// conditioner against a run-length reference.
module tb_key_debounce_pulse;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_a = 1'b0;
  logic btn_b = 1'b1;

  logic [2:0] lvl_o;
  logic [2:0] prs_o;
  logic [2:0] rls_o;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  key_debounce_pulse #(
    .WIDTH(24), .DEBOUNCE_TICKS(24'd4), .ACTIVE_LOW(1'b0)
  ) u_a (
    .clk(clk), .rst(rst), .btn_in(btn_a),
    .btn_level(lvl_o[0]), .press_pulse(prs_o[0]),
    .release_pulse(rls_o[0])
  );

  key_debounce_pulse #(
    .WIDTH(24), .DEBOUNCE_TICKS(24'd4), .ACTIVE_LOW(1'b1)
  ) u_b (
    .clk(clk), .rst(rst), .btn_in(btn_b),
    .btn_level(lvl_o[1]), .press_pulse(prs_o[1]),
    .release_pulse(rls_o[1])
  );

  key_debounce_pulse #(
    .WIDTH(24), .DEBOUNCE_TICKS(24'd1), .ACTIVE_LOW(1'b0)
  ) u_c (
    .clk(clk), .rst(rst), .btn_in(btn_a),
    .btn_level(lvl_o[2]), .press_pulse(prs_o[2]),
    .release_pulse(rls_o[2])
  );

  // Reference: the FSM sees the pressed value two
  // edges late; a run of T+1 disagreeing samples
  // flips the level and emits one strobe.
  int   tk[3] = '{4, 4, 1};
  logic d1[3];
  logic d2[3];
  logic m_lvl[3];
  logic m_prs[3];
  logic m_rls[3];
  int   run[3];
  int   n_prs[3];
  int   n_rls[3];

  task automatic chk(input string tag, input int m,
                     input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut%0d got %b want %b",
             tag, m, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag,
                         input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic p, input logic r);
    logic seen;
    btn_a = p;
    btn_b = ~p;
    rst   = r;
    @(posedge clk);
    for (int m = 0; m < 3; m++) begin
      m_prs[m] = 1'b0;
      m_rls[m] = 1'b0;
      if (r) begin
        d1[m] = 1'b0;
        d2[m] = 1'b0;
        m_lvl[m] = 1'b0;
        run[m] = 0;
      end else begin
        seen  = d2[m];
        d2[m] = d1[m];
        d1[m] = p;
        if (seen != m_lvl[m]) run[m]++;
        else run[m] = 0;
        if (run[m] == tk[m] + 1) begin
          m_lvl[m] = ~m_lvl[m];
          m_prs[m] = m_lvl[m];
          m_rls[m] = ~m_lvl[m];
          run[m] = 0;
        end
      end
    end
    @(negedge clk);
    for (int m = 0; m < 3; m++) begin
      chk("level", m, lvl_o[m], m_lvl[m]);
      chk("press", m, prs_o[m], m_prs[m]);
      chk("release", m, rls_o[m], m_rls[m]);
      n_prs[m] += int'(prs_o[m]);
      n_rls[m] += int'(rls_o[m]);
    end
  endtask

  task automatic clr_counts();
    for (int m = 0; m < 3; m++) begin
      n_prs[m] = 0;
      n_rls[m] = 0;
    end
  endtask

  // Holds p for up to 30 steps and returns the
  // step index at which dut a / dut c pulsed.
  task automatic wait_pulse(input logic p,
                            input logic want_press,
                            output int ia, output int ic);
    ia = -1;
    ic = -1;
    for (int i = 0; i < 30; i++) begin
      step(p, 1'b0);
      if (ia < 0 && (want_press ? prs_o[0] : rls_o[0]))
        ia = i;
      if (ic < 0 && (want_press ? prs_o[2] : rls_o[2]))
        ic = i;
    end
  endtask

  initial begin
    int ia, ic;
    logic pv;
    int len;
    for (int m = 0; m < 3; m++) begin
      d1[m] = 1'b0; d2[m] = 1'b0; m_lvl[m] = 1'b0;
      m_prs[m] = 1'b0; m_rls[m] = 1'b0; run[m] = 0;
    end
    clr_counts();

    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    clr_counts();
    wait_pulse(1'b1, 1'b1, ia, ic);
    chk_int("clean_press_t4", ia, 6);
    chk_int("clean_press_t1", ic, 3);

    for (int i = 0; i < 1000; i++) step(1'b1, 1'b0);
    chk_int("hold_press_a", n_prs[0], 1);
    chk_int("hold_press_b", n_prs[1], 1);
    chk_int("hold_release_a", n_rls[0], 0);

    clr_counts();
    wait_pulse(1'b0, 1'b0, ia, ic);
    chk_int("release_t4", ia, 6);
    chk_int("release_t1", ic, 3);
    chk_int("release_count_b", n_rls[1], 1);

    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    clr_counts();
    wait_pulse(1'b1, 1'b1, ia, ic);
    chk_int("bounce_press", ia, 6);
    chk_int("bounce_count_b", n_prs[1], 1);
    wait_pulse(1'b0, 1'b0, ia, ic);

    clr_counts();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk_int("rst_mid_no_pulse", n_prs[0], 0);
    wait_pulse(1'b1, 1'b1, ia, ic);
    chk_int("rst_mid_press", ia, 6);
    wait_pulse(1'b0, 1'b0, ia, ic);

    pv = 1'b0;
    for (int k = 0; k < 600; k++) begin
      pv  = ~pv;
      len = ($urandom_range(0, 3) == 0)
            ? int'($urandom_range(6, 12))
            : int'($urandom_range(1, 6));
      for (int j = 0; j < len; j++)
        step(pv, ($urandom_range(0, 299) == 0));
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
